// File: rtl/uart_slave_if.sv
// Bus slot interface shared by the system-bus slaves (ROM, GPIO, UART).
// All strobes are active-low; RdData/Rdy_ are returned one cycle after the strobe.
interface uart_slave_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic              CS_;
    logic              As_;
    logic              RW;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WrData;
    logic [DATA_W-1:0] RdData;
    logic              Rdy_;

    modport master (
        output CS_, As_, RW, Addr, WrData,
        input  RdData, Rdy_
    );

    modport slave (
        input  CS_, As_, RW, Addr, WrData,
        output RdData, Rdy_
    );
endinterface

// File: rtl/uart_slave.sv
// Memory-mapped 8N1 UART: STATUS at word 0, DATA at word 1, level IRQs for RX/TX done.
// Define UART_FERR_EN to add the sticky framing-error flag (STATUS bit4) that also drives irq_rx.
module uart_slave #(
    parameter int CLK_DIV = 217,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 30
) (
    input  logic          clk,
    input  logic          reset_,
    uart_slave_if.slave   bus,
    input  logic          UartRX,
    output logic          UartTX,
    output logic          irq_rx,
    output logic          irq_tx
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Bus side
    logic              access, wr_status, wr_data;
    logic              rdy_q;
    logic [DATA_W-1:0] rd_data_q, rd_data_d, status_word;

    // Flags
    logic rx_done_q, rx_done_d, tx_done_q, tx_done_d;
    logic rx_done_set, tx_done_set, ferr_set, ferr_flag;

    // TX path
    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_line_q, tx_line_d;
    logic             tx_start;

    // RX path
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic [1:0]       rx_sync_q;
    logic             rx_prev_q;
    logic             rx_line;

    logic unused_bus;
    assign unused_bus = ^{bus.Addr[ADDR_W-1:1], bus.WrData[DATA_W-1:8]};

    assign access    = !bus.CS_ && !bus.As_;
    assign wr_status = access && !bus.RW && !bus.Addr[0];
    assign wr_data   = access && !bus.RW &&  bus.Addr[0];
    assign tx_start  = wr_data && (tx_state_q == TX_IDLE);
    assign rx_line   = rx_sync_q[1];

    assign status_word = DATA_W'({ferr_flag, tx_state_q != TX_IDLE, rx_state_q != RX_IDLE,
                                  tx_done_q, rx_done_q});

    always_comb begin
        rd_data_d = '0;
        if (access && bus.RW) begin
            rd_data_d = bus.Addr[0] ? DATA_W'(rx_data_q) : status_word;
        end
    end

    // Software clear first, hardware set last: a coincident set wins.
    always_comb begin
        rx_done_d = rx_done_q;
        tx_done_d = tx_done_q;
        if (wr_status && !bus.WrData[0]) rx_done_d = 1'b0;
        if (wr_status && !bus.WrData[1]) tx_done_d = 1'b0;
        if (rx_done_set) rx_done_d = 1'b1;
        if (tx_done_set) tx_done_d = 1'b1;
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_line_d   = tx_line_q;
        tx_done_set = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_start) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = bus.WrData[7:0];
                    tx_line_d  = 1'b0;
                end
            end
            TX_START: begin
                tx_cnt_d = tx_cnt_q + 1'b1;
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift_q[0];
                end
            end
            TX_DATA: begin
                tx_cnt_d = tx_cnt_q + 1'b1;
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_line_d  = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_line_d  = tx_shift_q[1];
                    end
                end
            end
            default: begin
                tx_cnt_d = tx_cnt_q + 1'b1;
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d  = TX_IDLE;
                    tx_cnt_d    = '0;
                    tx_done_set = 1'b1;
                end
            end
        endcase
    end

    // Start edge is checked again at half a bit so short glitches are rejected;
    // from then on every sample lands a whole bit later, i.e. at a bit centre.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_done_set = 1'b0;
        ferr_set    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_line) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                rx_cnt_d = rx_cnt_q + 1'b1;
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_line ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                rx_cnt_d = rx_cnt_q + 1'b1;
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_line, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            default: begin
                rx_cnt_d = rx_cnt_q + 1'b1;
                if (rx_cnt_q == BIT_LAST) begin
                    rx_state_d = RX_IDLE;
                    rx_cnt_d   = '0;
                    if (rx_line) begin
                        rx_data_d   = rx_shift_q;
                        rx_done_set = 1'b1;
                    end else begin
                        ferr_set = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rdy_q      <= 1'b1;
            rd_data_q  <= '0;
            rx_done_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
        end else begin
            rdy_q      <= !access;
            rd_data_q  <= rd_data_d;
            rx_done_q  <= rx_done_d;
            tx_done_q  <= tx_done_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_sync_q  <= {rx_sync_q[0], UartRX};
            rx_prev_q  <= rx_line;
        end
    end

`ifdef UART_FERR_EN
    logic ferr_q, ferr_d;

    always_comb begin
        ferr_d = ferr_q;
        if (wr_status && !bus.WrData[4]) ferr_d = 1'b0;
        if (ferr_set) ferr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) ferr_q <= 1'b0;
        else         ferr_q <= ferr_d;
    end

    assign ferr_flag = ferr_q;
    assign irq_rx    = rx_done_q | ferr_q;
`else
    logic unused_ferr;
    assign unused_ferr = ferr_set;
    assign ferr_flag   = 1'b0;
    assign irq_rx      = rx_done_q;
`endif

    assign irq_tx     = tx_done_q;
    assign UartTX     = tx_line_q;
    assign bus.Rdy_   = rdy_q;
    assign bus.RdData = rd_data_q;
endmodule

// File: tb/tb_uart_slave.sv
// Directed-plus-random bench for uart_slave at 16 clocks per bit; expectations come from
// byte-level frame construction and a flag model of the STATUS register.
module tb_uart_slave;
    localparam int DIV = 16;

    logic clk = 1'b0;
    logic reset_;
    logic UartRX;
    logic UartTX;
    logic irq_rx;
    logic irq_tx;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model of software-visible state
    logic       m_rx_done, m_tx_done, m_ferr;
    logic [7:0] m_rx_data;

    uart_slave_if #(.ADDR_W(30), .DATA_W(32)) bus_if ();

    uart_slave #(.CLK_DIV(DIV), .DATA_W(32), .ADDR_W(30)) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus_if),
        .UartRX (UartRX),
        .UartTX (UartTX),
        .irq_rx (irq_rx),
        .irq_tx (irq_tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic f;
`ifdef UART_FERR_EN
        f = m_ferr;
`else
        f = 1'b0;
`endif
        return {27'b0, f, 2'b00, m_tx_done, m_rx_done};
    endfunction

    function automatic logic exp_irq_rx();
`ifdef UART_FERR_EN
        return m_rx_done | m_ferr;
`else
        return m_rx_done;
`endif
    endfunction

    task automatic strobe(input logic rw, input logic a0, input logic [31:0] wd);
        logic [29:0] a;
        a    = 30'($urandom);
        a[0] = a0;
        bus_if.CS_    = 1'b0;
        bus_if.As_    = 1'b0;
        bus_if.RW     = rw;
        bus_if.Addr   = a;
        bus_if.WrData = wd;
    endtask

    task automatic idle_bus();
        bus_if.CS_ = 1'b1;
        bus_if.As_ = 1'b1;
    endtask

    task automatic bus_rd(input logic a0, output logic [31:0] rd);
        strobe(1'b1, a0, $urandom);
        @(negedge clk);
        chk("rd_rdy", 32'(bus_if.Rdy_), 32'd0);
        rd = bus_if.RdData;
        idle_bus();
        @(negedge clk);
        chk("rd_rdy_end", 32'(bus_if.Rdy_), 32'd1);
        chk("rd_data_idle", bus_if.RdData, 32'd0);
    endtask

    task automatic bus_wr(input logic a0, input logic [31:0] wd);
        strobe(1'b0, a0, wd);
        @(negedge clk);
        chk("wr_rdy", 32'(bus_if.Rdy_), 32'd0);
        chk("wr_rddata", bus_if.RdData, 32'd0);
        idle_bus();
        if (!a0) begin
            if (!wd[0]) m_rx_done = 1'b0;
            if (!wd[1]) m_tx_done = 1'b0;
            if (!wd[4]) m_ferr    = 1'b0;
        end
        @(negedge clk);
    endtask

    // Writes byte b to DATA and checks every line cycle against {stop, b, start}.
    task automatic tx_frame(input logic [7:0] b, input logic dbl, input logic [7:0] b2);
        logic [9:0]  bits;
        logic [31:0] wd;
        bits = {1'b1, b, 1'b0};
        wd = $urandom;
        wd[7:0] = b;
        strobe(1'b0, 1'b1, wd);
        @(negedge clk);
        chk("tx_wr_rdy", 32'(bus_if.Rdy_), 32'd0);
        if (dbl) bus_if.WrData = {24'h0, b2};
        else     idle_bus();
        for (int i = 0; i < 10 * DIV; i++) begin
            chk("tx_line", 32'(UartTX), 32'(bits[i / DIV]));
            if (i == 1) begin
                if (dbl) chk("tx_drop_rdy", 32'(bus_if.Rdy_), 32'd0);
                idle_bus();
            end
            if (i == 40) strobe(1'b1, 1'b0, 32'h0);
            if (i == 41) begin
                chk("tx_status_busy", bus_if.RdData, 32'h8 | exp_status());
                idle_bus();
            end
            if (i == 10 * DIV - 1) chk("irq_tx_pre", 32'(irq_tx), 32'(m_tx_done));
            @(negedge clk);
        end
        m_tx_done = 1'b1;
        chk("irq_tx", 32'(irq_tx), 32'd1);
        chk("tx_idle_line", 32'(UartTX), 32'd1);
    endtask

    // Drives one frame on UartRX; optionally issues a STATUS write-0 at cycle clr_cyc.
    task automatic rx_frame(input logic [7:0] b, input logic stopb, input int clr_cyc,
                            output int rise_cyc);
        logic [9:0] bits;
        bits = {stopb, b, 1'b0};
        rise_cyc = -1;
        for (int c = 0; c < 10 * DIV; c++) begin
            UartRX = bits[c / DIV];
            if (c == clr_cyc) strobe(1'b0, 1'b0, 32'h0);
            else if (c == clr_cyc + 1) idle_bus();
            @(negedge clk);
            if (irq_rx && rise_cyc < 0) rise_cyc = c;
        end
        UartRX = 1'b1;
        repeat (20) @(negedge clk);
        if (clr_cyc >= 0) begin
            m_rx_done = 1'b0;
            m_tx_done = 1'b0;
            m_ferr    = 1'b0;
        end
        if (stopb) begin
            m_rx_done = 1'b1;
            m_rx_data = b;
        end else begin
`ifdef UART_FERR_EN
            m_ferr = 1'b1;
`endif
        end
        chk("irq_rx", 32'(irq_rx), 32'(exp_irq_rx()));
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;
        int          rise_a, rise_b;

        m_rx_done = 1'b0; m_tx_done = 1'b0; m_ferr = 1'b0; m_rx_data = 8'h00;
        reset_ = 1'b0;
        UartRX = 1'b1;
        bus_if.RW = 1'b1; bus_if.Addr = '0; bus_if.WrData = '0;
        idle_bus();
        repeat (3) @(negedge clk);
        chk("rst_txline", 32'(UartTX), 32'd1);
        chk("rst_rdy", 32'(bus_if.Rdy_), 32'd1);
        chk("rst_rddata", bus_if.RdData, 32'd0);
        chk("rst_irq", {30'b0, irq_rx, irq_tx}, 32'd0);
        reset_ = 1'b1;
        @(negedge clk);
        bus_rd(1'b0, rd);
        chk("rst_status", rd, 32'd0);

        // Address strobe without chip select is not an access
        bus_if.CS_ = 1'b1; bus_if.As_ = 1'b0; bus_if.RW = 1'b1;
        @(negedge clk);
        chk("no_cs_rdy", 32'(bus_if.Rdy_), 32'd1);
        idle_bus();
        @(negedge clk);

        tx_frame(8'hA5, 1'b0, 8'h00);
        bus_wr(1'b0, 32'h0);
        chk("irq_tx_clr", 32'(irq_tx), 32'd0);
        for (int k = 0; k < 2; k++) begin
            b = 8'($urandom);
            tx_frame(b, 1'b0, 8'h00);
            bus_wr(1'b0, 32'hFFFF_FFFC | 32'($urandom_range(0, 3)) & 32'hFFFF_FFEC);
            bus_wr(1'b0, 32'h0);
        end

        // Second write while busy is dropped
        tx_frame(8'h11, 1'b1, 8'h22);
        for (int k = 0; k < 12 * DIV; k++) begin
            if (k % 8 == 0) chk("tx_no_second", 32'(UartTX), 32'd1);
            @(negedge clk);
        end
        bus_rd(1'b0, rd);
        chk("tx_status_done", rd, exp_status());
        bus_wr(1'b0, 32'h0);

        rx_frame(8'h3C, 1'b1, -1, rise_a);
        bus_rd(1'b0, rd);
        chk("rx_status", rd, exp_status());
        bus_rd(1'b1, rd);
        chk("rx_data", rd, {24'h0, m_rx_data});

        // Back-to-back reads: DATA then STATUS on consecutive cycles
        strobe(1'b1, 1'b1, 32'h0);
        @(negedge clk);
        strobe(1'b1, 1'b0, 32'h0);
        chk("b2b_rdy0", 32'(bus_if.Rdy_), 32'd0);
        chk("b2b_data", bus_if.RdData, {24'h0, m_rx_data});
        @(negedge clk);
        idle_bus();
        chk("b2b_rdy1", 32'(bus_if.Rdy_), 32'd0);
        chk("b2b_status", bus_if.RdData, exp_status());
        @(negedge clk);

        // Random bytes overwrite the data register even with RX_DONE still set
        for (int k = 0; k < 2; k++) begin
            b = 8'($urandom);
            rx_frame(b, 1'b1, -1, rise_a);
            bus_rd(1'b1, rd);
            chk("rx_data_rand", rd, {24'h0, m_rx_data});
        end
        bus_wr(1'b0, 32'h0);
        chk("irq_rx_clr", 32'(irq_rx), 32'd0);

        // Short low glitch is rejected
        UartRX = 1'b0;
        repeat (4) @(negedge clk);
        UartRX = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        bus_rd(1'b0, rd);
        chk("glitch_status", rd, exp_status());
        chk("glitch_irq", 32'(irq_rx), 32'd0);

        // Framing error: stop bit 0
        rx_frame(8'($urandom), 1'b0, -1, rise_a);
        bus_rd(1'b0, rd);
        chk("ferr_status", rd, exp_status());
        bus_rd(1'b1, rd);
        chk("ferr_data_kept", rd, {24'h0, m_rx_data});
        bus_wr(1'b0, 32'h0);
        chk("ferr_irq_clr", 32'(irq_rx), 32'd0);

        // Clear written in the very cycle a byte completes: set wins
        rx_frame(8'($urandom), 1'b1, -1, rise_a);
        chk("rise_found", 32'(rise_a >= 0), 32'd1);
        bus_wr(1'b0, 32'h0);
        chk("irq_rx_clr2", 32'(irq_rx), 32'd0);
        rx_frame(8'($urandom), 1'b1, rise_a, rise_b);
        bus_rd(1'b0, rd);
        chk("set_wins_status", rd, exp_status());
        bus_rd(1'b1, rd);
        chk("set_wins_data", rd, {24'h0, m_rx_data});

        // Reset in the middle of a TX frame of all-zero data
        bus_wr(1'b1, 32'h0);
        repeat (30) @(negedge clk);
        chk("mid_tx_low", 32'(UartTX), 32'd0);
        reset_ = 1'b0;
        #1;
        chk("mid_rst_txline", 32'(UartTX), 32'd1);
        chk("mid_rst_irq", {30'b0, irq_rx, irq_tx}, 32'd0);
        repeat (2) @(negedge clk);
        reset_ = 1'b1;
        m_rx_done = 1'b0; m_tx_done = 1'b0; m_ferr = 1'b0; m_rx_data = 8'h00;
        @(negedge clk);
        bus_rd(1'b0, rd);
        chk("post_rst_status", rd, 32'd0);
        bus_rd(1'b1, rd);
        chk("post_rst_data", rd, 32'd0);
        for (int k = 0; k < 12 * DIV; k++) begin
            if (k % 16 == 0) chk("post_rst_line", 32'(UartTX), 32'd1);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
